rv32i_trace_monitor: RTL
========================

# rv32i_trace_monitor

Synthesizable execution tracer that sits beside the `rv32i` core and replaces the hard-coded 64-iteration testbench loop. It watches `instrAddr`, `instruction` and `aluResult` every cycle, records them into a parametrised trace buffer (linear or circular), and stops on a halt instruction, an invalid (all-zero) fetch, or a cycle limit. After stopping, it drains the trace oldest-first over a valid/ready read port.

## Interface

Parameters:

- `ADDR_W`, 16: width of `instrAddr`.
- `DEPTH`, 64: trace entries; power of 2, ≥ 2.
- `MAX_CYCLES`, 64: cycle limit per run, ≥ 1.
- `HALT_INSTR`, 32'h0000_0073: instruction word that ends a run (ecall).
- `WRAP`, 0: 0 = linear buffer (stop recording when full); 1 = circular buffer (overwrite oldest).

Ports:

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; accepted only in IDLE or DONE.
- `instrAddr`  in  ADDR_W  core PC.
- `instruction`  in  32  core fetched instruction.
- `aluResult`  in  32  core ALU result.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `halt_cause`  out  2  0 none, 1 halt instr, 2 invalid fetch, 3 cycle limit.
- `overflow`  out  1  at least one entry was dropped or overwritten this run.
- `cycle_count`  out  $clog2(MAX_CYCLES+1)  cycles captured this run.
- `entry_count`  out  $clog2(DEPTH+1)  entries held (decrements on read).
- `rd_valid`  out  1  an entry is available (DONE and `entry_count` > 0).
- `rd_ready`  in  1  consumer accepts the current entry.
- `rd_addr`  out  ADDR_W  entry PC.
- `rd_instr`  out  32  entry instruction.
- `rd_alu`  out  32  entry ALU result.

## Operation

- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on a stop condition.
  - DONE → RUN on `start`.
  - `start` in RUN is ignored.
- **Entering RUN:** clears the write and read pointers, `entry_count`, `cycle_count`, `overflow` and `halt_cause`.
- **Capture in RUN:** each rising edge captures {`instrAddr`, `instruction`, `aluResult`} and increments `cycle_count`.
- **Stop conditions,** evaluated on the captured word in this priority:
  - `instruction == HALT_INSTR` → cause 1.
  - `instruction == 0` or any X/Z bit (X/Z in simulation only) → cause 2.
  - `cycle_count` reaching `MAX_CYCLES` → cause 3.
  - The stopping word itself is recorded (subject to the full rules below).
- **Full with WRAP=0:** further captures are discarded and `overflow` is set. The run continues until a stop condition; `cycle_count` keeps counting.
- **Full with WRAP=1:** overwrite the oldest entry, advance the read pointer, keep `entry_count` at DEPTH, and set `overflow`.
- **Readout:** only in DONE, oldest entry first.
  - A pop occurs when `rd_valid & rd_ready`: the read pointer advances and `entry_count` decrements.
  - `rd_*` are combinational from the buffer at the read pointer and hold while `rd_valid` is high and not popped.
  - `rd_*` are don't-care when `rd_valid` is low.
- **Restart:** `start` in DONE begins a new run even if entries remain; the remaining entries are lost.
- **Pointers:** `$clog2(DEPTH)` bits and wrap naturally; `cycle_count` saturates at MAX_CYCLES.

## Timing

- **Reset values:**
  - State IDLE.
  - `running`, `done`, `overflow`, `rd_valid` = 0.
  - `halt_cause`, `cycle_count`, `entry_count` = 0.
  - Buffer contents undefined.
- **Start:** `start` sampled high at edge N → `running` high after edge N. The first capture happens at edge N+1.
- **Stop:** a stop condition present before edge M → captured at edge M. After edge M: `done` = 1, `running` = 0, `halt_cause` valid, and `rd_valid` = 1 if `entry_count` > 0.
- **Read latency:** zero; data is valid in the same cycle as `rd_valid`. Back-to-back pops give one entry per cycle.
- **Reset mid-run or mid-readout:** immediate return to reset values. No partial pop or capture completes.

## Test plan

- **Halt instruction:** DEPTH=64, WRAP=0; program of 5 words with the 5th = 32'h0000_0073. Required: `done` after 5 captures, `halt_cause`=1, `entry_count`=5, `cycle_count`=5, `overflow`=0; five pops return PCs 0,4,8,12,16 in order.
- **Invalid fetch:** instruction 0 at PC 12. Required: `halt_cause`=2, 4 entries, last `rd_instr`=0.
- **Linear full:** DEPTH=4, WRAP=0, MAX_CYCLES=10, no halt. Required: `halt_cause`=3, `cycle_count`=10, `entry_count`=4, `overflow`=1; reads return PCs 0,4,8,12.
- **Circular full:** same stimulus with WRAP=1. Required: `entry_count`=4, `overflow`=1; reads return PCs 24,28,32,36.
- **Backpressure:** `rd_ready` toggling 1,0,0,1. Required: `rd_*` stable while stalled, no entry lost or duplicated.
- **Reset and restart:**
  - `rst_n` pulsed low mid-RUN → all outputs return to reset values immediately.
  - `start` during RUN is ignored, with `cycle_count` unaffected.
  - `start` in DONE with 2 unread entries → `entry_count`=0 and a fresh run begins.

Source files
------------

// File: rtl/rv32i_trace_monitor.sv
// Execution tracer for the rv32i core: captures {PC, instruction, ALU result} each cycle
// into a linear or circular trace buffer, stops on halt/invalid fetch/cycle limit, then drains.
module rv32i_trace_monitor #(
    parameter int          ADDR_W     = 16,
    parameter int          DEPTH      = 64,
    parameter int          MAX_CYCLES = 64,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               instrAddr,
    input  logic [31:0]                     instruction,
    input  logic [31:0]                     aluResult,
    output logic                            running,
    output logic                            done,
    output logic [1:0]                      halt_cause,
    output logic                            overflow,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycle_count,
    output logic [$clog2(DEPTH+1)-1:0]      entry_count,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [ADDR_W-1:0]               rd_addr,
    output logic [31:0]                     rd_instr,
    output logic [31:0]                     rd_alu
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_CYCLES+1);
    localparam int EW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       instr;
        logic [31:0]       alu;
    } entry_t;

    state_t        state, stateNxt;
    entry_t        mem [DEPTH];
    entry_t        rdEntry;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] cycNxt;
    logic [1:0]    stopCause;
    logic          instrBad, full, capture, write, pop, startRun;

    assign capture  = (state == RUN);
    assign startRun = start && (state != RUN);
    assign full     = (entry_count == EW'(DEPTH));
    // A full circular buffer still writes: the slot at wrPtr is the oldest entry.
    assign write    = capture && (!full || WRAP);
    assign rd_valid = (state == DONE) && (entry_count != '0);
    assign pop      = rd_valid && rd_ready;
    assign running  = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        cycNxt    = (cycle_count == CW'(MAX_CYCLES)) ? cycle_count : cycle_count + 1'b1;
        // The X/Z term only ever fires in four-state simulation.
        instrBad  = (instruction == 32'd0) || ((^instruction) === 1'bx);
        stopCause = 2'd0;
        if (instruction == HALT_INSTR)      stopCause = 2'd1;
        else if (instrBad)                  stopCause = 2'd2;
        else if (cycNxt == CW'(MAX_CYCLES)) stopCause = 2'd3;

        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = RUN;
            RUN:     if (stopCause != 2'd0) stateNxt = DONE;
            DONE:    if (start) stateNxt = RUN;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            cycle_count <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
            halt_cause  <= 2'd0;
        end else begin
            state <= stateNxt;
            if (startRun) begin
                wrPtr       <= '0;
                rdPtr       <= '0;
                cycle_count <= '0;
                entry_count <= '0;
                overflow    <= 1'b0;
                halt_cause  <= 2'd0;
            end else if (capture) begin
                cycle_count <= cycNxt;
                halt_cause  <= stopCause;
                if (write) wrPtr <= wrPtr + 1'b1;
                if (!full) begin
                    entry_count <= entry_count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (WRAP) rdPtr <= rdPtr + 1'b1;
                end
            end else if (pop) begin
                rdPtr       <= rdPtr + 1'b1;
                entry_count <= entry_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write) mem[wrPtr] <= '{addr: instrAddr, instr: instruction, alu: aluResult};
    end

    assign rdEntry  = mem[rdPtr];
    assign rd_addr  = rdEntry.addr;
    assign rd_instr = rdEntry.instr;
    assign rd_alu   = rdEntry.alu;
endmodule
